led_chain_node: RTL and testbench
=================================

LED_CHAIN_NODE -- requirements
Module: led_chain_node

Interface
REQ-001 SHALL have parameter CHANNELS, 3, colour channels per node.
REQ-002 SHALL have parameter BITS, 8, bits per channel.
REQ-003 SHALL have parameter LATCH_CYCLES, 500, idle clk cycles after the last CKI edge before latching.
REQ-004 SHALL have parameter SYNC_STAGES, 2, synchronizer depth on cki/sdi (minimum 2).
REQ-005 SHALL have port clk  in  1  single system clock; all state on its rising edge.
REQ-006 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port cki  in  1  serial clock from the upstream node (asynchronous to clk).
REQ-008 SHALL have port sdi  in  1  serial data from the upstream node (asynchronous to clk).
REQ-009 SHALL have port cko  out  1  forwarded serial clock to the downstream node.
REQ-010 SHALL have port sdo  out  1  forwarded serial data to the downstream node.
REQ-011 SHALL have port rgb  out  CHANNELS*BITS  latched frame; channel 0 MSB first-received bit is bit [CHANNELS*BITS-1].
REQ-012 SHALL have port latch_strobe  out  1  one-cycle pulse when rgb updates.
REQ-013 SHALL have port frame_error  out  1  one-cycle pulse when a partial frame is discarded.
REQ-014 SHALL have port relay_active  out  1  high while the node forwards data.

Function
REQ-015 SHALL synchronize cki and sdi through SYNC_STAGES flops, then detect a cki rising edge with one extra register (edge pulse SYNC_STAGES+1 clks after the pin edge).
REQ-016 SHALL, on a cki edge while not relaying, shift the synchronized sdi into the LSB of a FRAME_BITS = CHANNELS*BITS shift register and increment bit_cnt.
REQ-017 SHALL enter RELAY when bit_cnt reaches FRAME_BITS; further edges do not alter the shift register or bit_cnt.
REQ-018 SHALL use states LOAD -> ARMED (first FRAME_BITS bits captured) -> RELAY (the next cki edge seen); any latch or discard event returns the node to LOAD.
REQ-019 SHALL drive cko/sdo as registered copies of the synchronized cki/sdi only in RELAY, otherwise 0; this suppresses the edge that completed loading.
REQ-020 SHALL hold idle_cnt, width $clog2(LATCH_CYCLES+1), cleared on every cki edge, incrementing each clk and saturating at LATCH_CYCLES.
REQ-021 SHALL, in the cycle idle_cnt first equals LATCH_CYCLES: if bit_cnt == FRAME_BITS, copy shift register to rgb and pulse latch_strobe; if 0 < bit_cnt < FRAME_BITS, discard, keep rgb, and pulse frame_error; if bit_cnt == 0, do nothing; in all cases clear bit_cnt and return to LOAD.
REQ-022 SHALL give a cki edge priority when an edge and a timeout fall in the same cycle: the counter is cleared and no latch or discard occurs.
REQ-023 SHALL assert relay_active in ARMED and RELAY.
REQ-024 SHALL fire latch_strobe and frame_error at most once per idle period.

Reset
REQ-025 SHALL, on reset_n low, immediately force rgb=0, cko=0, sdo=0, latch_strobe=0, frame_error=0, relay_active=0, bit_cnt=0, idle_cnt=LATCH_CYCLES (saturated, so no spurious latch), state=LOAD, and synchronizer flops=0.
REQ-026 SHALL discard a frame in progress when reset asserts mid-frame; after release, the first edge is treated as bit 0.

Structure
REQ-027 SHALL place the frame-width function, the state enum (LOAD, ARMED, RELAY) and the default parameter constants in shared package led_pkg.
REQ-028 SHALL implement synchronization and rising-edge detection in one sub-module, sync_edge, instantiated twice (cki with edge output, sdi data only).
REQ-029 SHALL be synthesizable: no initial blocks or delays; the free-running internal oscillator is replaced by clk.

Verification (CHANNELS=3, BITS=8, LATCH_CYCLES=500, cki period 20 clks)
REQ-030 SHALL verify: 24 bits 0xFF8001, then 600 clks idle -> rgb=0xFF8001, latch_strobe one pulse, cko stays 0 throughout.
REQ-031 SHALL verify: 48 bits 0x123456 then 0xABCDEF, then idle -> rgb=0x123456; cko/sdo reproduce 23 forwarded edges carrying 0xABCDEF bits 22..0, with a (SYNC_STAGES+2)-clk lag.
REQ-032 SHALL verify: 10 bits, then idle -> frame_error one pulse, rgb unchanged, next 24-bit frame latches correctly.
REQ-033 SHALL verify: a cki edge placed so its detection coincides with idle_cnt==LATCH_CYCLES -> no latch; a latch occurs 500 clks later.
REQ-034 SHALL verify: reset_n pulsed low after 12 bits -> all outputs 0 asynchronously; then 24 bits 0x00AA55 -> rgb=0x00AA55.
REQ-035 SHALL verify: 1000 idle clks after reset -> no latch_strobe or frame_error.

Source files
------------

// File: rtl/led_pkg.sv
// led_pkg: shared constants, frame width helper and state encoding
// for the daisy-chained LED node.
package led_pkg;

    localparam int DEF_CHANNELS     = 3;
    localparam int DEF_BITS         = 8;
    localparam int DEF_LATCH_CYCLES = 500;
    localparam int DEF_SYNC_STAGES  = 2;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        ARMED = 2'd1,
        RELAY = 2'd2
    } state_t;

    function automatic int frame_bits(input int channels, input int bits);
        return channels * bits;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// sync_edge: multi-flop synchronizer plus registered rising-edge detect.
// o_data is the delayed copy aligned with the o_rise pulse.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_async,
    output logic o_data,
    output logic o_rise
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;
    logic              r_rise;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_prev <= r_sync[STAGES-1];
            r_rise <= r_sync[STAGES-1] & ~r_prev;
        end
    end

    assign o_data = r_prev;
    assign o_rise = r_rise;

endmodule

// File: rtl/led_chain_node.sv
// led_chain_node: captures one frame from the serial chain, relays the
// rest downstream, and latches or discards after an idle timeout.
module led_chain_node
    import led_pkg::*;
#(
    parameter int CHANNELS     = DEF_CHANNELS,
    parameter int BITS         = DEF_BITS,
    parameter int LATCH_CYCLES = DEF_LATCH_CYCLES,
    parameter int SYNC_STAGES  = DEF_SYNC_STAGES
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     cki,
    input  logic                     sdi,
    output logic                     cko,
    output logic                     sdo,
    output logic [CHANNELS*BITS-1:0] rgb,
    output logic                     latch_strobe,
    output logic                     frame_error,
    output logic                     relay_active
);

    localparam int FB = frame_bits(CHANNELS, BITS);
    localparam int CW = $clog2(FB + 1);
    localparam int IW = $clog2(LATCH_CYCLES + 1);
    localparam logic [CW-1:0] FB_C   = CW'(FB);
    localparam logic [CW-1:0] FB_M1  = CW'(FB - 1);
    localparam logic [IW-1:0] LAT_C  = IW'(LATCH_CYCLES);
    localparam logic [IW-1:0] LAT_M1 = IW'(LATCH_CYCLES - 1);

    logic w_cki_d;
    logic w_cki_rise;
    logic w_sdi_d;
    logic w_sdi_rise_unused;
    logic w_timeout;
    logic w_load;

    state_t          r_state;
    state_t          w_state_nx;
    logic [FB-1:0]   r_shift;
    logic [CW-1:0]   r_bit_cnt;
    logic [IW-1:0]   r_idle;
    logic [FB-1:0]   r_rgb;
    logic            r_latch;
    logic            r_err;
    logic            r_cko;
    logic            r_sdo;

    sync_edge #(.STAGES(SYNC_STAGES)) u_cki_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_async (cki),
        .o_data  (w_cki_d),
        .o_rise  (w_cki_rise)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_sdi_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_async (sdi),
        .o_data  (w_sdi_d),
        .o_rise  (w_sdi_rise_unused)
    );

    // A cki edge in the timeout cycle wins: the counter restarts instead.
    assign w_timeout = !w_cki_rise && (r_idle == LAT_M1);
    assign w_load    = w_cki_rise && (r_state == LOAD);

    always_comb begin
        w_state_nx = r_state;
        if (w_timeout) begin
            w_state_nx = LOAD;
        end else if (w_cki_rise) begin
            unique case (r_state)
                LOAD:    if (r_bit_cnt == FB_M1) w_state_nx = ARMED;
                ARMED:   w_state_nx = RELAY;
                default: w_state_nx = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= LOAD;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_idle    <= LAT_C;
            r_rgb     <= '0;
            r_latch   <= 1'b0;
            r_err     <= 1'b0;
            r_cko     <= 1'b0;
            r_sdo     <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_latch <= 1'b0;
            r_err   <= 1'b0;
            if (w_cki_rise) begin
                r_idle <= '0;
            end else if (r_idle != LAT_C) begin
                r_idle <= r_idle + IW'(1);
            end
            if (w_timeout) begin
                r_bit_cnt <= '0;
                if (r_bit_cnt == FB_C) begin
                    r_rgb   <= r_shift;
                    r_latch <= 1'b1;
                end else if (r_bit_cnt != '0) begin
                    r_err <= 1'b1;
                end
            end else if (w_load) begin
                r_shift   <= {r_shift[FB-2:0], w_sdi_d};
                r_bit_cnt <= r_bit_cnt + CW'(1);
            end
            // Only edges that start while relaying may raise cko.
            r_cko <= (r_state == RELAY) && w_cki_d && (w_cki_rise || r_cko);
            r_sdo <= (r_state == RELAY) && w_sdi_d;
        end
    end

    assign rgb          = r_rgb;
    assign latch_strobe = r_latch;
    assign frame_error  = r_err;
    assign cko          = r_cko;
    assign sdo          = r_sdo;
    assign relay_active = (r_state != LOAD);

endmodule

// File: tb/tb_led_chain_node.sv
// tb_led_chain_node: directed and random frames checked against a
// bit-queue model of the chain protocol.
module tb_led_chain_node;

    localparam int FB  = 24;
    localparam int LAT = 500;
    localparam int SS  = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cki;
    logic          sdi;
    logic          cko;
    logic          sdo;
    logic [FB-1:0] rgb;
    logic          latch_strobe;
    logic          frame_error;
    logic          relay_active;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int n_strobe = 0;
    int n_err    = 0;
    int t_strobe = 0;
    int t_cko    = 0;
    int t_pin    = 0;
    bit fwd_q[$];
    bit p_cko    = 1'b0;

    bit            m_q[$];
    logic [FB-1:0] m_rgb;
    int s_strobe, s_err, s_fwd;

    led_chain_node dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cki          (cki),
        .sdi          (sdi),
        .cko          (cko),
        .sdo          (sdo),
        .rgb          (rgb),
        .latch_strobe (latch_strobe),
        .frame_error  (frame_error),
        .relay_active (relay_active)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (latch_strobe) begin
            n_strobe = n_strobe + 1;
            t_strobe = cyc;
        end
        if (frame_error) n_err = n_err + 1;
        if (cko && !p_cko) begin
            fwd_q.push_back(sdo);
            t_cko = cyc;
        end
        p_cko = cko;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total = total + 1;
        assert (obs === exp)
        else begin
            bad = bad + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input bit b);
        cki = 1'b0;
        sdi = b;
        repeat (10) @(negedge clk);
        cki   = 1'b1;
        t_pin = cyc;
        m_q.push_back(b);
        repeat (10) @(negedge clk);
        cki = 1'b0;
    endtask

    task automatic send_word(input logic [63:0] data, input int n);
        logic [63:0] d;
        d = data;
        for (int i = n - 1; i >= 0; i--) send_bit(d[i]);
    endtask

    task automatic begin_frame();
        m_q.delete();
        s_strobe = n_strobe;
        s_err    = n_err;
        s_fwd    = fwd_q.size();
    endtask

    task automatic end_frame(input string tag);
        int          exp_s;
        int          exp_e;
        int          exp_nf;
        int          got_nf;
        logic [63:0] exp_v;
        logic [63:0] got_v;
        cki = 1'b0;
        repeat (600) @(negedge clk);
        exp_s = 0;
        exp_e = 0;
        if (m_q.size() >= FB) begin
            exp_s = 1;
            for (int i = 0; i < FB; i++) m_rgb[FB-1-i] = m_q[i];
        end else if (m_q.size() > 0) begin
            exp_e = 1;
        end
        exp_nf = (m_q.size() > FB + 1) ? m_q.size() - FB - 1 : 0;
        got_nf = fwd_q.size() - s_fwd;
        exp_v  = '0;
        got_v  = '0;
        for (int i = 0; i < exp_nf; i++) begin
            exp_v = {exp_v[62:0], m_q[FB+1+i]};
            if (s_fwd + i < fwd_q.size())
                got_v = {got_v[62:0], fwd_q[s_fwd+i]};
            else
                got_v = {got_v[62:0], 1'b0};
        end
        chk({tag, ".strobes"}, 64'(n_strobe - s_strobe), 64'(exp_s));
        chk({tag, ".errors"}, 64'(n_err - s_err), 64'(exp_e));
        chk({tag, ".rgb"}, 64'(rgb), 64'(m_rgb));
        chk({tag, ".fwd_edges"}, 64'(got_nf), 64'(exp_nf));
        if (exp_nf > 0) chk({tag, ".fwd_bits"}, got_v, exp_v);
        chk({tag, ".relay_idle"}, 64'(relay_active), 64'd0);
        m_q.delete();
    endtask

    initial begin
        int t2;
        int len;
        logic [63:0] rnd;
        reset_n = 1'b0;
        cki     = 1'b0;
        sdi     = 1'b0;
        m_rgb   = '0;
        repeat (3) @(negedge clk);
        chk("reset.outs", 64'({rgb, cko, sdo, latch_strobe, frame_error,
                               relay_active}), 64'd0);
        reset_n = 1'b1;

        begin_frame();
        repeat (1000) @(negedge clk);
        chk("idle.strobes", 64'(n_strobe - s_strobe), 64'd0);
        chk("idle.errors", 64'(n_err - s_err), 64'd0);
        chk("idle.rgb", 64'(rgb), 64'd0);

        begin_frame();
        send_word(64'hFF8001, 24);
        end_frame("f24");
        chk("f24.rgb_const", 64'(rgb), 64'hFF8001);

        begin_frame();
        send_word(64'h123456ABCDEF, 48);
        chk("f48.lag", 64'(t_cko - t_pin), 64'(SS + 2));
        end_frame("f48");
        chk("f48.rgb_const", 64'(rgb), 64'h123456);

        begin_frame();
        send_word(64'h2A5, 10);
        end_frame("f10");
        chk("f10.rgb_kept", 64'(rgb), 64'h123456);

        begin_frame();
        send_word(64'h5A0FC3, 24);
        end_frame("f24b");

        begin_frame();
        rnd = 64'({$urandom} | 32'h1);
        send_word(rnd, 24);
        repeat (LAT - 10) @(negedge clk);
        cki = 1'b1;
        sdi = 1'($urandom);
        t2  = cyc;
        m_q.push_back(sdi);
        repeat (10) @(negedge clk);
        chk("tie.no_latch", 64'(n_strobe - s_strobe), 64'd0);
        end_frame("tie");
        chk("tie.latch_time", 64'(t_strobe - t2), 64'(SS + 2 + LAT));

        begin_frame();
        send_word(64'hABC, 12);
        #3 reset_n = 1'b0;
        #1 chk("arst.outs", 64'({rgb, cko, sdo, latch_strobe, frame_error,
                                 relay_active}), 64'd0);
        m_rgb = '0;
        @(negedge clk);
        reset_n = 1'b1;
        begin_frame();
        send_word(64'h00AA55, 24);
        end_frame("post_rst");

        for (int k = 0; k < 3; k++) begin
            begin_frame();
            len = $urandom_range(1, 40);
            rnd = {$urandom, $urandom};
            send_word(rnd, len);
            end_frame($sformatf("rnd%0d", k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
